// File: rtl/switch_pkg.sv
// Shared constants and helpers for the N-port packet switch.
package switch_pkg;

    localparam int MAX_PORTS  = 8;
    localparam int DROP_CNT_W = 16;

    // True when exactly one bit of the mask is set.
    function automatic logic onehot_valid(input logic [MAX_PORTS-1:0] mask);
        return (mask != '0) && ((mask & (mask - MAX_PORTS'(1))) == '0);
    endfunction

    // Low bit of field idx inside a flat bus made of w-bit fields.
    function automatic int lo_bit(input int idx, input int w);
        return idx * w;
    endfunction

    // Increment with wrap-around to 0 at n.
    function automatic int wrap_inc(input int v, input int n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/switch_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer,
// then moves the pointer one past the winner. The pointer holds when idle.
module switch_rr_arbiter
    import switch_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] gidx;
    logic          found;
    int            idx;

    // Scan upward from ptr with wrap; first requester wins.
    always_comb begin
        grant = '0;
        gidx  = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            if (!found && req[PW'(idx)]) begin
                found = 1'b1;
                gidx  = PW'(idx);
            end
        end
        if (found) grant[gidx] = 1'b1;
    end

    // Pointer advances only when a grant is issued.
    always_ff @(posedge clk) begin
        if (rst)
            ptr <= '0;
        else if (found)
            ptr <= PW'(wrap_inc(int'(gidx), N));
    end

endmodule

// File: rtl/switch_nport.sv
// N-port packet switch: per-input holding register, per-output show-ahead
// FIFO and round-robin arbiter. Multicast bits drain independently.
// Optional macro SWITCH_STATS_EN adds per-output pop counters.
module switch_nport
    import switch_pkg::*;
#(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_PORTS-1:0]           in_valid,
    output logic [NUM_PORTS-1:0]           in_ready,
    input  logic [NUM_PORTS*NUM_PORTS-1:0] in_source,
    input  logic [NUM_PORTS*NUM_PORTS-1:0] in_target,
    input  logic [NUM_PORTS*DATA_W-1:0]    in_data,
    output logic [NUM_PORTS-1:0]           out_valid,
    input  logic [NUM_PORTS-1:0]           out_ready,
    output logic [NUM_PORTS*NUM_PORTS-1:0] out_source,
    output logic [NUM_PORTS*NUM_PORTS-1:0] out_target,
    output logic [NUM_PORTS*DATA_W-1:0]    out_data,
    output logic [NUM_PORTS-1:0]           fifo_full,
`ifdef SWITCH_STATS_EN
    output logic [NUM_PORTS*16-1:0]        stat_pkt_count,
`endif
    output logic [DROP_CNT_W-1:0]          drop_count
);

    localparam int N  = NUM_PORTS;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [N-1:0]      src;
        logic [N-1:0]      tgt;
        logic [DATA_W-1:0] data;
    } pkt_t;

    pkt_t [N-1:0]          in_pkt;
    pkt_t [N-1:0]          hold;
    pkt_t [N-1:0]          push_pkt;
    logic [N-1:0]          hold_v;
    logic [N-1:0][N-1:0]   rem;        // [input][output]
    logic [N-1:0][N-1:0]   rem_next;   // [input][output]
    logic [N-1:0][N-1:0]   req;        // [output][input]
    logic [N-1:0][N-1:0]   grant;      // [output][input]
    logic [N-1:0][N-1:0]   grant_col;  // [input][output]
    logic [N-1:0]          space;
    logic [N-1:0]          push;
    logic [N-1:0]          pop;
    logic [N-1:0]          load;
    logic [N-1:0]          drop;
    logic [DROP_CNT_W:0]   drop_sum;

    // Split the flat input buses into per-input packets.
    always_comb begin
        in_pkt = '0;
        for (int i = 0; i < N; i++) begin
            in_pkt[i].src  = in_source[lo_bit(i, N) +: N];
            in_pkt[i].tgt  = in_target[lo_bit(i, N) +: N];
            in_pkt[i].data = in_data[lo_bit(i, DATA_W) +: DATA_W];
        end
    end

    // Requests: held packet still owes this output and the FIFO can take it.
    always_comb begin
        req = '0;
        for (int o = 0; o < N; o++)
            for (int i = 0; i < N; i++)
                req[o][i] = hold_v[i] && rem[i][o] && space[o];
    end

    // Transpose grants per input and mux the winning packet to each FIFO.
    always_comb begin
        grant_col = '0;
        push_pkt  = '0;
        for (int o = 0; o < N; o++) begin
            for (int i = 0; i < N; i++) begin
                grant_col[i][o] = grant[o][i];
                if (grant[o][i]) push_pkt[o] = hold[i];
            end
        end
    end

    // Input accept: register empty or its last pending bits drain this cycle.
    always_comb begin
        rem_next = '0;
        in_ready = '0;
        load     = '0;
        drop     = '0;
        for (int i = 0; i < N; i++) begin
            rem_next[i] = rem[i] & ~grant_col[i];
            in_ready[i] = !rst && (!hold_v[i] || (rem_next[i] == '0));
            load[i]     = in_valid[i] && in_ready[i] && (in_pkt[i].tgt != '0);
            drop[i]     = in_valid[i] && in_ready[i] && (in_pkt[i].tgt == '0);
        end
        drop_sum = {1'b0, drop_count} + (DROP_CNT_W+1)'($countones(drop));
    end

    // Holding registers: load a new packet or retire granted target bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_v <= '0;
            rem    <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (load[i]) begin
                    hold_v[i] <= 1'b1;
                    rem[i]    <= in_pkt[i].tgt;
                    hold[i]   <= in_pkt[i];
                end else begin
                    hold_v[i] <= hold_v[i] && (rem_next[i] != '0);
                    rem[i]    <= rem_next[i];
                end
            end
        end
    end

    // Saturating count of zero-target packets (several may drop per cycle).
    always_ff @(posedge clk) begin
        if (rst)
            drop_count <= '0;
        else if (drop != '0)
            drop_count <= drop_sum[DROP_CNT_W] ? '1 : drop_sum[DROP_CNT_W-1:0];
    end

    for (genvar o = 0; o < N; o++) begin : g_out
        pkt_t          mem [FIFO_DEPTH];
        pkt_t          head;
        logic [AW-1:0] wr_ptr;
        logic [AW-1:0] rd_ptr;
        logic [CW-1:0] count;

        switch_rr_arbiter #(.N(N)) u_arb (
            .clk   (clk),
            .rst   (rst),
            .req   (req[o]),
            .grant (grant[o])
        );

        assign out_valid[o] = !rst && (count != '0);
        assign pop[o]       = out_valid[o] && out_ready[o];
        assign push[o]      = grant[o] != '0;
        // Push at full is fine when the head leaves in the same cycle.
        assign space[o]     = (count < CW'(FIFO_DEPTH)) || pop[o];
        assign fifo_full[o] = count == CW'(FIFO_DEPTH);
        assign head         = mem[rd_ptr];

        assign out_source[o*N +: N]           = head.src;
        assign out_target[o*N +: N]           = head.tgt;
        assign out_data[o*DATA_W +: DATA_W]   = head.data;

        // FIFO storage write port.
        always_ff @(posedge clk) begin
            if (push[o]) mem[wr_ptr] <= push_pkt[o];
        end

        // FIFO pointers and occupancy.
        always_ff @(posedge clk) begin
            if (rst) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push[o]) wr_ptr <= wr_ptr + AW'(1);
                if (pop[o])  rd_ptr <= rd_ptr + AW'(1);
                case ({push[o], pop[o]})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end
        end

`ifdef SWITCH_STATS_EN
        logic [15:0] stat;

        // Per-output delivered-packet counter, wraps naturally.
        always_ff @(posedge clk) begin
            if (rst)
                stat <= '0;
            else if (pop[o])
                stat <= stat + 16'd1;
        end

        assign stat_pkt_count[o*16 +: 16] = stat;
`endif
    end

endmodule

// File: tb/tb_switch_nport.sv
// Directed bench for switch_nport (4 ports, 8-bit data, depth 8).
module tb_switch_nport;

    localparam int N  = 4;
    localparam int DW = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   in_valid, in_ready, out_valid, out_ready, fifo_full;
    logic [N*N-1:0] in_source, in_target, out_source, out_target;
    logic [N*DW-1:0] in_data, out_data;
    logic [15:0]    drop_count;
`ifdef SWITCH_STATS_EN
    logic [N*16-1:0] stat_pkt_count;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    switch_nport #(.NUM_PORTS(N), .DATA_W(DW), .FIFO_DEPTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_source  (in_source),
        .in_target  (in_target),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_source (out_source),
        .out_target (out_target),
        .out_data   (out_data),
        .fifo_full  (fifo_full),
`ifdef SWITCH_STATS_EN
        .stat_pkt_count (stat_pkt_count),
`endif
        .drop_count (drop_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive(input int i, input logic [3:0] tgt, input logic [7:0] d);
        in_valid[i]          = 1'b1;
        in_target[i*N +: N]  = tgt;
        in_source[i*N +: N]  = 4'(1 << i);
        in_data[i*DW +: DW]  = d;
    endtask

    task automatic reset_dut();
        in_valid = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        settle();
    endtask

    function automatic logic [7:0] odata(input int o);
        return out_data[o*DW +: DW];
    endfunction

    function automatic logic [3:0] osrc(input int o);
        return out_source[o*N +: N];
    endfunction

    function automatic logic [3:0] otgt(input int o);
        return out_target[o*N +: N];
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] got [16];
        int n, n3c, pos3c;
        logic xfer;

        rst = 1'b1; in_valid = '0; out_ready = '1;
        in_source = '0; in_target = '0; in_data = '0;
        tick(); tick();
        rst = 1'b0;
        settle();
        check("rst_in_ready", in_ready, 4'hF);
        check("rst_out_valid", out_valid, 4'h0);
        check("rst_fifo_full", fifo_full, 4'h0);
        check("rst_drop", drop_count, 16'h0);

        // single unicast: input 0 -> output 1
        drive(0, 4'b0010, 8'hA5);
        tick();
        in_valid = '0; settle();
        check("uni_lat1", out_valid, 4'h0);
        tick();
        check("uni_valid", out_valid, 4'b0010);
        check("uni_data", odata(1), 8'hA5);
        check("uni_src", osrc(1), 4'b0001);
        check("uni_tgt", otgt(1), 4'b0010);
        tick();
        check("uni_once", out_valid, 4'h0);

        // contention: inputs 0,2,3 -> output 1, rr pointer fresh from reset
        reset_dut();
        drive(0, 4'b0010, 8'h11);
        drive(2, 4'b0010, 8'h22);
        drive(3, 4'b0010, 8'h33);
        tick();
        in_valid = '0; settle();
        check("con_ready0", in_ready, 4'b0011);
        check("con_lat", out_valid, 4'h0);
        tick();
        check("con_v1", out_valid, 4'b0010);
        check("con_d1", odata(1), 8'h11);
        check("con_s1", osrc(1), 4'b0001);
        check("con_ready1", in_ready, 4'b0111);
        tick();
        check("con_d2", odata(1), 8'h22);
        check("con_s2", osrc(1), 4'b0100);
        check("con_ready2", in_ready, 4'hF);
        tick();
        check("con_v3", out_valid, 4'b0010);
        check("con_d3", odata(1), 8'h33);
        check("con_s3", osrc(1), 4'b1000);
        tick();
        check("con_done", out_valid, 4'h0);

        // multicast 1101 with output 3 full and stalled
        reset_dut();
        out_ready = 4'b0111;
        for (int j = 0; j < 8; j++) begin
            drive(0, 4'b1000, 8'(j));
            tick();
        end
        in_valid = '0;
        tick(); tick();
        check("mc_full", fifo_full, 4'b1000);
        drive(1, 4'b1101, 8'h3C);
        tick();
        in_valid = '0; settle();
        check("mc_ready_a", in_ready[1], 1'b0);
        tick();
        check("mc_valid", out_valid, 4'b1101);
        check("mc_d0", odata(0), 8'h3C);
        check("mc_d2", odata(2), 8'h3C);
        check("mc_ready_b", in_ready[1], 1'b0);
        tick();
        check("mc_ready_c", in_ready[1], 1'b0);
        check("mc_head3", odata(3), 8'h00);
        out_ready = '1; settle();
        check("mc_ready_rel", in_ready[1], 1'b1);
        n = 0; n3c = 0; pos3c = -1;
        for (int c = 0; c < 20; c++) begin
            if (out_valid[3]) begin
                if (odata(3) == 8'h3C) begin
                    n3c++;
                    pos3c = n;
                end
                n++;
            end
            tick();
        end
        check("mc_pops3", n, 9);
        check("mc_once", n3c, 1);
        check("mc_pos", pos3c, 8);

        // full FIFO on output 2: 10 packets, consumer stalled
        reset_dut();
        out_ready = 4'b1011;
        for (int j = 0; j < 9; j++) begin
            drive(0, 4'b0100, 8'(8'h40 + j));
            settle();
            check("ff_acc", in_ready[0], 1'b1);
            tick();
        end
        drive(0, 4'b0100, 8'h49);
        settle();
        check("ff_full", fifo_full, 4'b0100);
        check("ff_stall", in_ready[0], 1'b0);
        tick();
        check("ff_stall2", in_ready[0], 1'b0);
        check("ff_head", odata(2), 8'h40);
        out_ready = '1; settle();
        n = 0;
        for (int c = 0; c < 40; c++) begin
            xfer = in_valid[0] && in_ready[0];
            if (out_valid[2] && n < 16) begin
                got[n] = odata(2);
                n++;
            end
            tick();
            if (xfer) in_valid[0] = 1'b0;
        end
        check("ff_count", n, 10);
        for (int j = 0; j < 10; j++)
            check("ff_order", got[j], 8'(8'h40 + j));

        // zero-target drops, then reset with packets queued
        reset_dut();
        drive(0, 4'b0000, 8'h01);
        drive(1, 4'b0000, 8'h02);
        drive(2, 4'b0000, 8'h03);
        tick();
        in_valid = '0; settle();
        check("drop_cnt", drop_count, 16'd3);
        check("drop_none", out_valid, 4'h0);
        out_ready = '0;
        for (int i = 0; i < 4; i++) drive(i, 4'(1 << i), 8'(8'h50 + i));
        tick();
        in_valid = '0;
        tick();
        check("q_valid", out_valid, 4'hF);
        rst = 1'b1; settle();
        check("rst_hi_ready", in_ready, 4'h0);
        check("rst_hi_valid", out_valid, 4'h0);
        tick();
        rst = 1'b0; settle();
        check("rst_mid_valid", out_valid, 4'h0);
        check("rst_mid_drop", drop_count, 16'h0);
        check("rst_mid_ready", in_ready, 4'hF);
        check("rst_mid_full", fifo_full, 4'h0);
        tick(); tick();
        check("rst_mid_quiet", out_valid, 4'h0);

`ifdef SWITCH_STATS_EN
        reset_dut();
        out_ready = '1;
        for (int j = 0; j < 5; j++) begin
            drive(1, 4'b0001, 8'(j));
            tick();
        end
        in_valid = '0;
        repeat (4) tick();
        check("stat0", stat_pkt_count[15:0], 16'd5);
        check("stat_rest", stat_pkt_count[63:16], 32'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/switch_nport.md
Name: switch_nport

Overview:
- Parametrised N-port packet switch. Each input has a holding register; each output has a show-ahead FIFO and a per-output round-robin arbiter.
- Generalises the 4-port switch in three ways:
  - configurable port count, data width and FIFO depth;
  - valid/ready backpressure on both sides;
  - multicast delivery without loss when several inputs target one output in the same cycle.
- Sits between port adapters and the fabric in the same position as the 4-port switch.

Parameters:
- NUM_PORTS, 4, number of input/output port pairs (2..8); source/target fields are NUM_PORTS-bit one-hot/multi-hot masks.
- DATA_W, 8, payload width in bits.
- FIFO_DEPTH, 8, entries per output FIFO; power of two, at least 2.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  NUM_PORTS  per-input packet valid.
- in_ready  out  NUM_PORTS  per-input accept.
- in_source  in  NUM_PORTS*NUM_PORTS  per-input source mask; slice i = bits [i*NUM_PORTS +: NUM_PORTS].
- in_target  in  NUM_PORTS*NUM_PORTS  per-input destination mask (multi-hot means multicast).
- in_data  in  NUM_PORTS*DATA_W  per-input payload.
- out_valid  out  NUM_PORTS  per-output FIFO head valid.
- out_ready  in  NUM_PORTS  per-output consumer accept.
- out_source  out  NUM_PORTS*NUM_PORTS  head packet source mask.
- out_target  out  NUM_PORTS*NUM_PORTS  head packet original target mask.
- out_data  out  NUM_PORTS*DATA_W  head payload.
- fifo_full  out  NUM_PORTS  output FIFO count == FIFO_DEPTH.
- drop_count  out  16  saturating count of packets with all-zero target.

Behaviour:
- Reset (rst high at an edge): all holding registers invalid; FIFO counts, read/write pointers and RR pointers = 0; drop_count = 0. While rst is high, in_ready = 0 and out_valid = 0. Reset mid-operation discards all held and queued packets with no partial output; out_* data fields are don't-care while out_valid = 0.
- Input handshake: transfer when in_valid[i] && in_ready[i]. Each input holds hold_v, rem_mask, src, tgt, data.
  - in_ready[i] = !rst && (!hold_v[i] || (rem_mask[i] & ~grant_col[i]) == 0), i.e. ready when the register is empty or fully drains this cycle.
  - On transfer with in_target == 0: packet is accepted and discarded, drop_count += 1, saturating at 0xFFFF. hold_v is unchanged unless the register drains this cycle.
  - Otherwise the register loads the packet with rem_mask = in_target.
- Arbitration, each cycle, per output o:
  - req[i] = hold_v[i] && rem_mask[i][o] && space[o], where space[o] = (count[o] < FIFO_DEPTH) || (out_valid[o] && out_ready[o]). A simultaneous push and pop at full is therefore allowed.
  - At most one grant per output per cycle: the first requester at or after rr_ptr[o], scanning upward with wrap-around.
  - On a grant to input g, rr_ptr[o] <= (g+1) mod NUM_PORTS. With no grant, rr_ptr holds.
  - A granted input clears bit o of rem_mask. hold_v clears when rem_mask reaches 0 and no new load occurs.
  - Multicast bits drain independently across cycles, so partial delivery is allowed. No packet is ever lost or duplicated.
- FIFO:
  - Push writes {src, tgt, data} at wr_ptr[o], and wr_ptr increments with wrap.
  - Pop occurs when out_valid && out_ready; rd_ptr increments with wrap.
  - Count width is clog2(FIFO_DEPTH)+1. Push+pop in the same cycle leaves count unchanged. Pop when empty is impossible since out_valid = 0.
- Outputs: out_valid[o] = count[o] > 0; out_* show the FIFO head combinationally. While out_valid && !out_ready, head fields stay stable.
- Latency: in transfer at edge k, grant during cycle k+1, FIFO write at edge k+1, so out_valid is seen in the cycle after edge k+1 (2-edge latency) when uncontended.
- Ordering: packets from one input to one output leave in acceptance order.

Optional Feature:
- Macro SWITCH_STATS_EN.
- Defined: adds output port stat_pkt_count (NUM_PORTS*16). Each 16-bit per-output counter increments on every pop, wraps at 0xFFFF, and resets to 0.
- Undefined: the port and counters are absent; all other behaviour is identical.

Decomposition:
- Package switch_pkg holds:
  - MAX_PORTS = 8 and DROP_CNT_W = 16;
  - function onehot_valid(mask);
  - the index-slicing helper functions.
- One sub-module, switch_rr_arbiter: a NUM_PORTS-request round-robin arbiter with a registered pointer, update-on-grant, and one instance per output.
- FIFO storage stays inline.

Test Plan:
- Single unicast: input 0 sends target 0010, data 0xA5, out_ready all 1 -> out_valid[1] high exactly 2 edges later with data 0xA5 and source 0001; other outputs stay idle.
- Contention: inputs 0, 2 and 3 each send one packet to output 1 in the same cycle -> three packets leave output 1 in order 0, 2, 3 on consecutive cycles; in_ready[2] and in_ready[3] drop until their grant.
- Multicast with backpressure: input 1 sends target 1101, data 0x3C, with out_ready[3] = 0 and output 3 FIFO full -> outputs 0 and 2 deliver at once; in_ready[1] stays 0 until out_ready[3] = 1; output 3 then delivers 0x3C exactly once.
- Full FIFO: hold out_ready[2] = 0 and send 10 packets to output 2 -> fifo_full[2] asserts after 8; the 9th is held in the input register with in_ready = 0; release delivers all 10 in order with no loss.
- Zero target plus reset mid-flight: three packets with target 0000 -> drop_count = 3. Then assert rst for one cycle with 4 packets queued -> out_valid = 0 on all outputs, drop_count = 0, in_ready = 1 after rst falls.
- Stats build (SWITCH_STATS_EN): pop 5 packets from output 0 -> stat_pkt_count[0] = 5; other counters stay 0.
